median_window_gen: RTL and testbench

- Streaming 3x3 window generator. Converts a raster-order 8-bit pixel stream into packed 72-bit 3x3 neighbourhoods.
- Output is in the exact layout consumed by the median filter's in_matrix input; it sits directly upstream of that filter in the post-IDCT image path.
- Holds two line buffers and a 3x3 shift window.
- Emits one window per interior pixel, with a valid/ready handshake on both sides.

---
 rtl/median_window_gen_pkg.sv | 12 +
 rtl/median_window_gen_if.sv | 24 ++
 rtl/median_window_gen_line_buf.sv | 22 ++
 rtl/median_window_gen.sv | 149 ++++++++++++++
 tb/tb_median_window_gen.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/median_window_gen_pkg.sv
// Shared constants and FSM state type for the 3x3 median window generator.
package median_pkg;
  localparam int WIN_SIZE = 3;
  localparam int PIX_W    = 8;
  localparam int WIN_W    = WIN_SIZE * WIN_SIZE * PIX_W;  // 72-bit packed window

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    RUN
  } state_e;
endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / window-out stream bundle for median_window_gen.
// slave: the window generator's view; master: the upstream/downstream view.
interface median_window_gen_if;
  import median_pkg::*;

  logic [PIX_W-1:0] in_pixel;
  logic             in_sof;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] out_window;
  logic             out_valid;
  logic             out_ready;
  logic             out_eof;

  modport slave (
    input  in_pixel, in_sof, in_valid, out_ready,
    output in_ready, out_window, out_valid, out_eof
  );

  modport master (
    output in_pixel, in_sof, in_valid, out_ready,
    input  in_ready, out_window, out_valid, out_eof
  );
endinterface

// File: rtl/median_window_gen_line_buf.sv
// One line of pixel storage. Combinational read and registered write at the
// same address, so a write returns the old contents (read-before-write).
module median_line_buf #(
  parameter int DEPTH = 64,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // store the new pixel for this column; contents need no reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end
endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator: raster 8-bit pixels in, packed 72-bit
// neighbourhoods out (bits [i*24+j*8 +: 8] = row i, col j, row 0 oldest).
// One window per interior pixel, latency 1 from the accepting edge.
// Optional: define MEDIAN_WIN_COORD_EN to add out_row/out_col centre ports.
module median_window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  median_window_gen_if.slave            bus
`ifdef MEDIAN_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col
`endif
);
  import median_pkg::*;

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  state_e          state, state_nxt;
  logic [CW-1:0]   col, col_nxt, eff_col;
  logic [RW-1:0]   row, row_nxt, eff_row;
  logic            in_ready, xfer, load, emit, last_pix;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // win[i][j]: row i, column j; packing matches the output bit layout
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][PIX_W-1:0] win, win_nxt;

  logic             out_valid_q, out_eof_q;
  logic [WIN_W-1:0] out_window_q;

  assign in_ready       = !out_valid_q || bus.out_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_eof    = out_eof_q;
  assign bus.out_window = out_window_q;

  // transfer qualification and coordinates; an SOF pixel is always (0,0)
  always_comb begin
    xfer     = bus.in_valid && in_ready;
    eff_col  = bus.in_sof ? '0 : col;
    eff_row  = bus.in_sof ? '0 : row;
    // pixels before the first SOF are accepted but dropped
    load     = xfer && (state != WAIT_SOF || bus.in_sof);
    emit     = load && !bus.in_sof && state == RUN && col >= CW'(2);
    last_pix = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
  end

  // raster counters: col wraps into row, row wraps at end of frame
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    if (load) begin
      if (eff_col == COL_LAST) begin
        col_nxt = '0;
        row_nxt = (eff_row == ROW_LAST) ? '0 : RW'(eff_row + 1'b1);
      end else begin
        col_nxt = CW'(eff_col + 1'b1);
        row_nxt = eff_row;
      end
    end
  end

  // next-state: SOF (re)starts filling, row 2 starts output, last pixel ends
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_SOF: if (load) state_nxt = FILL;
      FILL:     if (load && eff_col == COL_LAST && eff_row == RW'(1)) state_nxt = RUN;
      RUN: begin
        if (load && bus.in_sof)  state_nxt = FILL;
        else if (emit && last_pix) state_nxt = WAIT_SOF;
      end
      default:  state_nxt = WAIT_SOF;
    endcase
  end

  // shift the window left and append {lb1[c], lb0[c], pix} as new column
  always_comb begin
    win_nxt = win;
    for (int i = 0; i < WIN_SIZE; i++) begin
      for (int j = 0; j < WIN_SIZE - 1; j++) win_nxt[i][j] = win[i][j+1];
    end
    win_nxt[0][WIN_SIZE-1] = lb1_rd;
    win_nxt[1][WIN_SIZE-1] = lb0_rd;
    win_nxt[2][WIN_SIZE-1] = bus.in_pixel;
  end

  // lb0 holds the previous line, lb1 the line before; lb0 cascades into lb1
  median_line_buf #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(CW)) u_lb0 (
    .clk(clk), .we(load), .addr(eff_col), .wr_data(bus.in_pixel), .rd_data(lb0_rd)
  );
  median_line_buf #(.DEPTH(IMG_WIDTH), .W(PIX_W), .AW(CW)) u_lb1 (
    .clk(clk), .we(load), .addr(eff_col), .wr_data(lb0_rd), .rd_data(lb1_rd)
  );

  // FSM state and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_SOF;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // window shift register; stale columns are flushed before col 2 emits
  always_ff @(posedge clk) begin
    if (load) win <= win_nxt;
  end

  // single output register: load on emit, otherwise drain on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_eof_q    <= 1'b0;
      out_window_q <= '0;
    end else if (emit) begin
      out_valid_q  <= 1'b1;
      out_eof_q    <= last_pix;
      out_window_q <= win_nxt;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
      out_eof_q    <= 1'b0;
    end
  end

`ifdef MEDIAN_WIN_COORD_EN
  // window centre coordinates travel with the window
  always_ff @(posedge clk) begin
    if (rst) begin
      out_row <= '0;
      out_col <= '0;
    end else if (emit) begin
      out_row <= RW'(row - 1'b1);
      out_col <= CW'(col - 1'b1);
    end
  end
`endif
endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 4x4 frame.
module tb_median_window_gen;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [71:0] win;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_window_gen_if bus();
`ifdef MEDIAN_WIN_COORD_EN
  logic [1:0] out_row, out_col;
`endif

  median_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef MEDIAN_WIN_COORD_EN
    , .out_row(out_row), .out_col(out_col)
`endif
  );

  int          checks = 0;
  int          fails  = 0;
  exp_t        exp_tab[4];
  logic [72:0] cap_q[$];
  bit          bp_arm = 1'b0;
  int          bp_left = 0;
  logic [71:0] held;

  function automatic logic [71:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [71:0] add_off(input logic [71:0] w, input logic [7:0] off);
    logic [71:0] r = w;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = r[k*8 +: 8] + off;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic send(input logic [7:0] pix, input logic sof);
    bit acc = 1'b0;
    int n = 0;
    @(negedge clk);
    bus.in_pixel = pix;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    while (!acc) begin
      #2;
      acc = bus.in_ready;
      @(posedge clk);
      if (!acc) begin
        n++;
        if (n > 200) begin
          checks++;
          fails++;
          $display("FAIL send_timeout: pixel %0d not accepted, required within 200 cycles", pix);
          return;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int p = 0; p < W * H; p++) send(8'(base + p), p == 0);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] off);
    chk({nm, "_count"}, 72'(cap_q.size()), 72'(4));
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      chk($sformatf("%s_win%0d", nm, i), cap_q[i][71:0], add_off(exp_tab[i].win, off));
      chk($sformatf("%s_eof%0d", nm, i), 72'(cap_q[i][72]), 72'(exp_tab[i].eof));
    end
    cap_q.delete();
  endtask

  // downstream: drives out_ready (with optional stall), records transfers
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_arm && bus.out_valid && bp_left == 0) begin
        bp_left = 5;
        held    = bus.out_window;
      end
      if (bp_left > 0) begin
        bus.out_ready = 1'b0;
        bp_left--;
        if (bp_left == 0) bp_arm = 1'b0;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (!bus.out_ready) begin
        chk("bp_in_ready", 72'(bus.in_ready), 72'(0));
        chk("bp_window_stable", bus.out_window, held);
      end
      if (bus.out_valid && bus.out_ready) cap_q.push_back({bus.out_eof, bus.out_window});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tab[0] = '{mk(0, 1, 2, 4, 5, 6, 8, 9, 10),      1'b0};
    exp_tab[1] = '{mk(1, 2, 3, 5, 6, 7, 9, 10, 11),     1'b0};
    exp_tab[2] = '{mk(4, 5, 6, 8, 9, 10, 12, 13, 14),   1'b0};
    exp_tab[3] = '{mk(5, 6, 7, 9, 10, 11, 13, 14, 15),  1'b1};

    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid",  72'(bus.out_valid), 72'(0));
    chk("reset_out_eof",    72'(bus.out_eof),   72'(0));
    chk("reset_out_window", bus.out_window,     72'(0));
    chk("reset_in_ready",   72'(bus.in_ready),  72'(1));
    @(negedge clk);
    rst = 1'b0;

    // basic frame with first-window latency
    for (int p = 0; p < 10; p++) send(8'(p), p == 0);
    #1;
    chk("no_window_before_px10", 72'(bus.out_valid), 72'(0));
    send(8'd10, 1'b0);
    #1;
    chk("first_window_valid", 72'(bus.out_valid), 72'(1));
    chk("first_window_data",  bus.out_window, exp_tab[0].win);
    chk("first_window_first_byte", 72'(bus.out_window[7:0]), 72'(0));
    chk("first_window_last_byte",  72'(bus.out_window[71:64]), 72'(10));
    for (int p = 11; p < 16; p++) send(8'(p), 1'b0);
    idle(4);
    check_frame("basic", 8'd0);

    // after eof the FSM waits for SOF: a frame without SOF makes nothing
    for (int p = 0; p < 16; p++) send(8'(200 + p), 1'b0);
    idle(4);
    chk("post_eof_discard_count", 72'(cap_q.size()), 72'(0));
    cap_q.delete();

    // backpressure on the first window
    bp_arm = 1'b1;
    send_frame(8'd0);
    idle(10);
    check_frame("backpressure", 8'd0);

    // garbage before SOF
    send(8'd99, 1'b0);
    send(8'd98, 1'b0);
    send_frame(8'd0);
    idle(4);
    check_frame("pre_sof", 8'd0);

    // SOF arrives mid-frame at pixel 7
    for (int p = 0; p < 7; p++) send(8'(p), p == 0);
    send_frame(8'd100);
    idle(4);
    check_frame("mid_sof", 8'd100);

    // reset while a window is pending
    for (int p = 0; p < 11; p++) send(8'(p), p == 0);
    #1;
    chk("pre_reset_valid", 72'(bus.out_valid), 72'(1));
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", 72'(bus.out_valid), 72'(0));
    chk("rst_mid_out_eof",   72'(bus.out_eof),   72'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    cap_q.delete();
    for (int p = 11; p < 16; p++) send(8'(p), 1'b0);
    send_frame(8'd0);
    idle(4);
    check_frame("post_reset", 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
